// File: rtl/multi_switch_filter_pkg.sv
// Shared timing constants and helpers for the switch conditioning block and
// any other block that needs the same sample timing.
package multi_switch_filter_pkg;

    // Board defaults: 100 MHz system clock, 500 Hz debounce sampling.
    localparam int DEF_CLK_HZ    = 100000000;
    localparam int DEF_SAMPLE_HZ = 500;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Register width able to hold 0..value-1, never narrower than one bit.
    function automatic int width_of(input int value);
        int w;
        w = clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    // Clocks per sample period.
    function automatic int calc_div(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/multi_switch_filter_debounce_ch.sv
// One conditioned channel: two-flop synchroniser, consecutive-sample
// debounce counter, registered level and one-clock edge pulses.
module debounce_ch
    import multi_switch_filter_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = width_of(STABLE_CNT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

    logic             s1_r;
    logic             s2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_r;
    logic             rise_r;
    logic             fall_r;

    logic [CNT_W-1:0] cnt_next_s;
    logic             out_next_s;
    logic             accept_s;

    // Next count/level: only sample ticks move state; a sample matching the
    // current level restarts the run, the last differing sample flips it.
    always_comb begin
        cnt_next_s = cnt_r;
        out_next_s = out_r;
        accept_s   = 1'b0;
        if (tick) begin
            if (s2_r == out_r) begin
                cnt_next_s = '0;
            end else if (cnt_r == LAST_CNT) begin
                cnt_next_s = '0;
                out_next_s = s2_r;
                accept_s   = 1'b1;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
        end
    end

    // Debounce state plus pulses aligned with the first cycle of a new level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r  <= '0;
            out_r  <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            out_r  <= out_next_s;
            rise_r <= accept_s & s2_r;
            fall_r <= accept_s & ~s2_r;
        end
    end

    assign dout = out_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/multi_switch_filter.sv
// N-channel switch/button conditioner: a shared prescaler produces the
// sample tick and each channel is debounced independently.
module multi_switch_filter
    import multi_switch_filter_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int SAMPLE_HZ  = DEF_SAMPLE_HZ,
    parameter int STABLE_CNT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            sample_tick
);

    localparam int DIV  = calc_div(CLK_HZ, SAMPLE_HZ);
    localparam int PW   = width_of(DIV);
    localparam logic [PW-1:0] LAST_PRE = PW'(DIV - 1);

    logic [PW-1:0] pre_cnt_r;
    logic [PW-1:0] pre_next_s;
    logic          tick_r;

    // Prescaler next value: count 0..DIV-1 and wrap.
    always_comb begin
        pre_next_s = pre_cnt_r;
        if (pre_cnt_r == LAST_PRE) begin
            pre_next_s = '0;
        end else begin
            pre_next_s = pre_cnt_r + PW'(1);
        end
    end

    // Prescaler and registered tick, high exactly while the count sits at DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            pre_cnt_r <= pre_next_s;
            tick_r    <= (pre_next_s == LAST_PRE);
        end
    end

    assign sample_tick = tick_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT (STABLE_CNT)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .tick  (tick_r),
            .din   (sw_in[g]),
            .dout  (sw_out[g]),
            .rise  (rise_pulse[g]),
            .fall  (fall_pulse[g])
        );
    end

endmodule
